// File: rtl/game_random_pkg.sv
// Shared types, LFSR constants and the round-robin pick helper for the random server.
package game_random_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'h1FFF;
  localparam logic [15:0] LFSR_TAPS = 16'h100B;

  // Widest requester vector the pick helper understands.
  localparam int unsigned RR_MAX = 32;
  localparam int unsigned RR_IW  = 5;

  // First set request at or above ptr, wrapping modulo n; returns ptr when nothing is set.
  function automatic int unsigned rr_pick(input logic [RR_MAX-1:0] req,
                                          input int unsigned       ptr,
                                          input int unsigned       n);
    int unsigned idx;
    logic        found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned k = 0; k < RR_MAX; k++) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if (!found && (k < n) && req[idx[RR_IW-1:0]]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/game_random.sv
// Free-running 16-bit Galois LFSR shared by the game logic.
module game_random
  import game_random_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] random
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Galois step: shift left, fold taps back in when the MSB falls out.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], 1'b0} ^ (lfsr_q[15] ? LFSR_TAPS : 16'h0000);
  end

  // LFSR register, reloads the seed on reset and never stalls otherwise.
  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign random = lfsr_q;

endmodule

// File: rtl/game_random_server.sv
// Round-robin server handing out bounded random values by rejection sampling on a shared LFSR.
module game_random_server
  import game_random_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned W           = 8,
  parameter int unsigned MAX_RETRIES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] max_value,
  output logic [N_REQ-1:0]   done,
  output logic [W-1:0]       rnd_value,
  output logic               rnd_fallback,
  output logic               busy
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned RW = $clog2(MAX_RETRIES + 1);

  logic [15:0]      lfsr_w;
  logic [W-1:0]     sample_c;

  state_e           state_q,  state_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]    idx_q,    idx_d;
  logic [W-1:0]     max_q,    max_d;
  logic [RW-1:0]    retry_q,  retry_d;
  logic [N_REQ-1:0] done_q,   done_d;
  logic [W-1:0]     val_q,    val_d;
  logic             fb_q,     fb_d;
  logic             busy_q,   busy_d;

  logic [IW-1:0]    grant_c;
  logic [IW-1:0]    next_ptr_c;

  game_random u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .random (lfsr_w)
  );

  assign sample_c = lfsr_w[W-1:0];

  // Upper LFSR bits are not part of the sample when W is narrower than the LFSR.
  if (W < 16) begin : g_unused_hi
    logic unused_lfsr_hi;
    assign unused_lfsr_hi = ^lfsr_w[15:W];
  end

  // Arbitration target and the pointer position following the current grant.
  always_comb begin
    grant_c    = IW'(rr_pick(RR_MAX'(req), 32'(rr_ptr_q), N_REQ));
    next_ptr_c = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + IW'(1);
  end

  // Arbiter and draw FSM next-state / next-output logic.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    idx_d    = idx_q;
    max_d    = max_q;
    retry_d  = retry_q;
    done_d   = '0;
    val_d    = '0;
    fb_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          idx_d   = grant_c;
          max_d   = max_value[grant_c*W +: W];
          retry_d = '0;
          state_d = DRAW;
        end
      end
      DRAW: begin
        if (!req[idx_q]) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr_c;
        end else if (sample_c <= max_q) begin
          done_d[idx_q] = 1'b1;
          val_d         = sample_c;
          state_d       = IDLE;
          rr_ptr_d      = next_ptr_c;
        end else if (retry_q == RW'(MAX_RETRIES - 1)) begin
          done_d[idx_q] = 1'b1;
          val_d         = max_q;
          fb_d          = 1'b1;
          state_d       = IDLE;
          rr_ptr_d      = next_ptr_c;
        end else begin
          retry_d = retry_q + RW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == DRAW);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      idx_q    <= '0;
      max_q    <= '0;
      retry_q  <= '0;
      done_q   <= '0;
      val_q    <= '0;
      fb_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q    <= idx_d;
      max_q    <= max_d;
      retry_q  <= retry_d;
      done_q   <= done_d;
      val_q    <= val_d;
      fb_q     <= fb_d;
      busy_q   <= busy_d;
    end
  end

  assign done         = done_q;
  assign rnd_value    = val_q;
  assign rnd_fallback = fb_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_game_random_server.sv
// Randomized self-checking bench for game_random_server against a transaction-level model.
module tb_game_random_server;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned MR = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] max_value;
  logic [N-1:0]   done;
  logic [W-1:0]   rnd_value;
  logic           rnd_fallback;
  logic           busy;

  int             n_checks = 0;
  int             n_fail   = 0;
  logic [15:0]    lfsr_m;
  int unsigned    ptr_m;

  game_random_server #(.N_REQ(N), .W(W), .MAX_RETRIES(MR)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .max_value    (max_value),
    .done         (done),
    .rnd_value    (rnd_value),
    .rnd_fallback (rnd_fallback),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h100B : 16'h0000);
  endfunction

  function automatic int unsigned pick(input logic [N-1:0] m, input int unsigned p);
    for (int unsigned k = 0; k < N; k++) begin
      if (m[(p + k) % N]) return (p + k) % N;
    end
    return p;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; the model LFSR follows the free-running hardware one.
  task automatic tick();
    @(posedge clk);
    #1;
    lfsr_m = lfsr_next(lfsr_m);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_val",  32'(rnd_value), 32'd0);
    check("rst_fb",   32'(rnd_fallback), 32'd0);
    check("rst_lfsr", 32'(dut.u_lfsr.random), 32'h1FFF);
    reset  = 1'b0;
    lfsr_m = 16'h1FFF;
    ptr_m  = 0;
  endtask

  // Hold a request mask until every member has been served; each drops req on its done.
  task automatic run_batch(input logic [N-1:0] mask, input logic [N*W-1:0] maxv, input bit scramble);
    int unsigned idx;
    int          lat;
    logic [W-1:0] mx, exp_val;
    logic        exp_fb;
    logic [15:0] s;
    req       = mask;
    max_value = maxv;
    while (mask != '0) begin
      idx     = pick(mask, ptr_m);
      mx      = maxv[idx*W +: W];
      s       = lfsr_m;
      lat     = MR + 1;
      exp_val = mx;
      exp_fb  = 1'b1;
      for (int k = 1; k <= int'(MR); k++) begin
        s = lfsr_next(s);
        if (s[W-1:0] <= mx) begin
          lat     = k + 1;
          exp_val = s[W-1:0];
          exp_fb  = 1'b0;
          break;
        end
      end
      for (int k = 1; k < lat; k++) begin
        tick();
        if (scramble) max_value[idx*W +: W] = W'($urandom);
        check("wait_done", 32'(done), 32'd0);
        check("wait_busy", 32'(busy), 32'd1);
      end
      tick();
      check("done",     32'(done), 32'(N'(1) << idx));
      check("value",    32'(rnd_value), 32'(exp_val));
      check("fallback", 32'(rnd_fallback), 32'(exp_fb));
      mask[idx] = 1'b0;
      req       = mask;
      ptr_m     = (idx + 1) % N;
    end
    tick();
    check("post_done", 32'(done), 32'd0);
    check("post_val",  32'(rnd_value), 32'd0);
    check("post_fb",   32'(rnd_fallback), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N*W-1:0] mv;
    logic [N-1:0]   m;
    reset     = 1'b1;
    req       = '0;
    max_value = '0;
    lfsr_m    = 16'h1FFF;
    ptr_m     = 0;
    repeat (2) @(posedge clk);
    #1;

    // First-sample accept from reset: done at cycle 2 with FE.
    do_reset();
    req       = 4'b0001;
    max_value = {N{8'hFF}};
    tick();
    tick();
    check("t1_done", 32'(done), 32'h1);
    check("t1_val",  32'(rnd_value), 32'hFE);
    check("t1_fb",   32'(rnd_fallback), 32'h0);
    req = '0;
    tick();
    check("t1_clear", 32'(done), 32'h0);

    // Four rejections then fallback to the bound at cycle 5.
    do_reset();
    req       = 4'b0001;
    max_value = {N{8'h0F}};
    for (int c = 1; c <= 4; c++) begin
      tick();
      check("t2_wait", 32'(done), 32'h0);
    end
    tick();
    check("t2_done", 32'(done), 32'h1);
    check("t2_val",  32'(rnd_value), 32'h0F);
    check("t2_fb",   32'(rnd_fallback), 32'h1);
    req = '0;
    tick();
    check("t2_clear", 32'(rnd_fallback), 32'h0);

    // All four held from reset: served 0,1,2,3 and the pointer wraps to 0.
    do_reset();
    run_batch(4'b1111, {N{8'hFF}}, 1'b0);
    check("t3_ptr", 32'(dut.rr_ptr_q), 32'h0);

    // Withdrawal mid-draw: no done, then requester 1 is granted.
    do_reset();
    req       = 4'b0001;
    max_value = '0;
    tick();
    check("t4_busy1", 32'(busy), 32'd1);
    req                 = 4'b0010;
    max_value[15:8]     = 8'hFF;
    tick();
    check("t4_busy0", 32'(busy), 32'd0);
    check("t4_done0", 32'(done), 32'd0);
    ptr_m = 1;
    run_batch(4'b0010, max_value, 1'b0);

    // Reset while drawing aborts cleanly.
    do_reset();
    req       = 4'b0001;
    max_value = '0;
    tick();
    tick();
    check("t5_busy", 32'(busy), 32'd1);
    do_reset();
    for (int c = 0; c < 6; c++) begin
      tick();
      check("t5_nostale", 32'(done), 32'd0);
    end

    // Full-range bound: always accepted, never fallback.
    for (int i = 0; i < 1000; i++) begin
      run_batch(N'(1) << $urandom_range(0, N - 1), {N{8'hFF}}, 1'b1);
    end

    // Zero bound: every result is zero.
    for (int i = 0; i < 100; i++) begin
      run_batch(N'(1) << $urandom_range(0, N - 1), '0, 1'b1);
    end

    // Random masks and bounds, with bounds scrambled after the grant.
    for (int i = 0; i < 300; i++) begin
      m = N'($urandom_range(1, (1 << N) - 1));
      for (int j = 0; j < int'(N); j++) begin
        case ($urandom_range(0, 3))
          0:       mv[j*W +: W] = '0;
          1:       mv[j*W +: W] = '1;
          default: mv[j*W +: W] = W'($urandom);
        endcase
      end
      run_batch(m, mv, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
